// File: rtl/clap_pkg.sv
// Shared amplitude-bus definitions for the clap synthesizer and clap detector.
package clap_pkg;
  localparam int AMP_W = 9;
  localparam logic [AMP_W-1:0] AMP_CENTER = 9'd256;

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
endpackage

// File: rtl/clap_tick_gen.sv
// Down-counting divider: one-cycle tick every DIV enabled cycles, synchronous clear.
module clap_tick_gen #(
  parameter int DIV        = 2500,
  parameter bit FIRST_TICK = 1'b1  // 1: tick on the first cycle after clear; 0: after DIV cycles
) (
  input  logic M_CLK,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  assign tick_o = en_i && !clr_i && (cnt == '0);

  always_ff @(posedge M_CLK or negedge rst_ni) begin
    if (!rst_ni)
      cnt <= '0;
    else if (clr_i)
      cnt <= FIRST_TICK ? '0 : CW'(DIV - 1);
    else if (en_i)
      cnt <= (cnt == '0) ? CW'(DIV - 1) : cnt - 1'b1;
  end
endmodule

// File: rtl/clap_synth.sv
// Clap-burst generator: decaying, sign-alternating bursts around mid-scale, repeated with a fixed gap.
//   state | meaning
//   IDLE  | output at centre, waiting for a trigger
//   BURST | emitting one sample per divider tick, then closing the burst
//   GAP   | silent spacing between consecutive bursts
module clap_synth
  import clap_pkg::*;
#(
  parameter int SAMPLE_DIV    = 2500,
  parameter int BURST_SAMPLES = 64,
  parameter int PEAK          = 120,
  parameter int DECAY_SHIFT   = 3,
  parameter int GAP_CYCLES    = 300_000
) (
  input  logic             M_CLK,
  input  logic             rst_ni,
  input  logic             trig_i,
  input  logic [2:0]       count_i,
  output logic [AMP_W-1:0] amplitude_o,
  output logic             sample_stb_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int IDX_W = $clog2(BURST_SAMPLES + 1);

  state_t           state;
  logic [2:0]       remaining;
  logic [7:0]       env;
  logic             sign;
  logic [IDX_W-1:0] idx;

  logic             div_tick;
  logic             gap_tick;
  logic [8:0]       env_dec;
  logic [7:0]       env_nxt;
  logic [AMP_W-1:0] sample;

  // Dividers are held in clear outside their state, so entering a state restarts them.
  clap_tick_gen #(.DIV(SAMPLE_DIV), .FIRST_TICK(1'b1)) u_sample_div (
    .M_CLK  (M_CLK),
    .rst_ni (rst_ni),
    .clr_i  (state != BURST),
    .en_i   (1'b1),
    .tick_o (div_tick)
  );

  clap_tick_gen #(.DIV(GAP_CYCLES), .FIRST_TICK(1'b0)) u_gap_div (
    .M_CLK  (M_CLK),
    .rst_ni (rst_ni),
    .clr_i  (state != GAP),
    .en_i   (1'b1),
    .tick_o (gap_tick)
  );

  assign env_dec = {1'b0, env >> DECAY_SHIFT} + 9'd1;
  assign env_nxt = ({1'b0, env} >= env_dec) ? 8'({1'b0, env} - env_dec) : 8'd0;
  assign sample  = sign ? AMP_CENTER + {1'b0, env} : AMP_CENTER - {1'b0, env};

  always_ff @(posedge M_CLK or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      remaining    <= '0;
      env          <= '0;
      sign         <= 1'b0;
      idx          <= '0;
      amplitude_o  <= AMP_CENTER;
      sample_stb_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      sample_stb_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: begin
          busy_o      <= 1'b0;
          amplitude_o <= AMP_CENTER;
          // A trigger in the done cycle belongs to the finished run and is dropped.
          if (trig_i && !done_o) begin
            remaining <= (count_i == 3'd0) ? 3'd1 : count_i;
            env       <= 8'(PEAK);
            sign      <= 1'b1;
            idx       <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          busy_o <= 1'b1;
          if (div_tick) begin
            if (idx == IDX_W'(BURST_SAMPLES)) begin
              amplitude_o <= AMP_CENTER;
              remaining   <= remaining - 3'd1;
              if (remaining == 3'd1) begin
                state  <= IDLE;
                done_o <= 1'b1;
                busy_o <= 1'b0;
              end else begin
                state <= GAP;
              end
            end else begin
              amplitude_o  <= sample;
              sample_stb_o <= 1'b1;
              sign         <= ~sign;
              env          <= env_nxt;
              idx          <= idx + 1'b1;
            end
          end
        end
        GAP: begin
          busy_o      <= 1'b1;
          amplitude_o <= AMP_CENTER;
          if (gap_tick) begin
            env   <= 8'(PEAK);
            sign  <= 1'b1;
            idx   <= '0;
            state <= BURST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
